// File: rtl/cnn_fifo_pkg.sv
// rtl/cnn_fifo_pkg.sv - shared FSM state type and default constants for the FIFO read packer
package cnn_fifo_pkg;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam int WIDTH_DEF = 8;
    localparam int PACK_DEF  = 4;
    localparam int STATS_W   = 16;

endpackage

// File: rtl/fifo_rd_out_stage.sv
// rtl/fifo_rd_out_stage.sv - output beat register and valid/ready handshake
// Optional beat/stall counters under FIFO_RD_PACKER_STATS_EN.
module fifo_rd_out_stage
    import cnn_fifo_pkg::*;
#(
    parameter int Width = WIDTH_DEF,
    parameter int Pack  = PACK_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  i_load,
    input  logic [Width*Pack-1:0] i_data,
    input  logic [Pack-1:0]       i_keep,
    input  logic                  i_last,
    output logic                  o_can_load,
    output logic [Width*Pack-1:0] o_m_data,
    output logic [Pack-1:0]       o_m_keep,
    output logic                  o_m_last,
    output logic                  o_m_valid,
`ifdef FIFO_RD_PACKER_STATS_EN
    output logic [STATS_W-1:0]    o_beats,
    output logic [STATS_W-1:0]    o_stall,
`endif
    input  logic                  i_m_ready
);

    logic                  r_valid;
    logic [Width*Pack-1:0] r_data;
    logic [Pack-1:0]       r_keep;
    logic                  r_last;

    // A new beat may enter while the current one is being accepted.
    assign o_can_load = !r_valid || i_m_ready;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_keep  <= '0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_keep  <= i_keep;
            r_last  <= i_last;
        end else if (r_valid && i_m_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_m_valid = r_valid;
    assign o_m_data  = r_data;
    assign o_m_keep  = r_keep;
    assign o_m_last  = r_last;

`ifdef FIFO_RD_PACKER_STATS_EN
    logic [STATS_W-1:0] r_beats;
    logic [STATS_W-1:0] r_stall;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_beats <= '0;
            r_stall <= '0;
        end else begin
            if (r_valid && i_m_ready) begin
                r_beats <= r_beats + 1'b1;
            end
            if (r_valid && !i_m_ready && (r_stall != '1)) begin
                r_stall <= r_stall + 1'b1;
            end
        end
    end

    assign o_beats = r_beats;
    assign o_stall = r_stall;
`endif

endmodule

// File: rtl/fifo_rd_packer.sv
// rtl/fifo_rd_packer.sv - packs Pack FIFO words into one output beat, with flush of partial beats
// Optional beats_o/stall_o counters under FIFO_RD_PACKER_STATS_EN.
module fifo_rd_packer
    import cnn_fifo_pkg::*;
#(
    parameter int Width = WIDTH_DEF,
    parameter int Pack  = PACK_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  empty_i,
    output logic                  read_o,
    input  logic [Width-1:0]      r_data_i,
    input  logic                  flush_i,
    output logic [Width*Pack-1:0] m_data_o,
    output logic [Pack-1:0]       m_keep_o,
    output logic                  m_last_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
`ifdef FIFO_RD_PACKER_STATS_EN
    output logic [STATS_W-1:0]    beats_o,
    output logic [STATS_W-1:0]    stall_o,
`endif
    output logic                  busy_o
);

    localparam int            CW     = $clog2(Pack + 1);
    localparam logic [CW-1:0] PACK_C = CW'(Pack);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CW-1:0]         r_cnt;
    logic [CW-1:0]         w_cnt_eff;
    logic                  r_inflight;
    logic [Width*Pack-1:0] r_pack;
    logic [Width*Pack-1:0] w_part_data;
    logic [Pack-1:0]       w_part_keep;
    logic [Width*Pack-1:0] w_ld_data;
    logic [Pack-1:0]       w_ld_keep;
    logic                  w_can_load;
    logic                  w_load_full;
    logic                  w_load_part;
    logic                  w_load;

    // cnt+inflight never exceeds Pack, so a full pack register never has a word in flight.
    assign w_load_full = (r_cnt == PACK_C) && w_can_load;
    assign w_load_part = (r_state == ST_FLUSH) && (r_cnt != PACK_C) && w_can_load;
    assign w_load      = w_load_full || w_load_part;

    // Treat the pack register as empty in the cycle it moves out, so reading never pauses.
    assign w_cnt_eff = w_load ? '0 : r_cnt;

    assign read_o = !rst_i && !empty_i && (r_state == ST_FILL)
                    && ((w_cnt_eff + CW'(r_inflight)) < PACK_C);

    always_comb begin
        w_part_keep = '0;
        w_part_data = '0;
        for (int i = 0; i < Pack; i++) begin
            w_part_keep[i] = (CW'(i) < r_cnt);
            if (w_part_keep[i]) begin
                w_part_data[i*Width +: Width] = r_pack[i*Width +: Width];
            end
        end
    end

    assign w_ld_data = w_load_full ? r_pack : w_part_data;
    assign w_ld_keep = w_load_full ? '1 : w_part_keep;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_FILL:  if (flush_i)     w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (!r_inflight) w_state_nxt = ST_FLUSH;
            ST_FLUSH: if (w_load_part) w_state_nxt = ST_FILL;
            default:                   w_state_nxt = ST_FILL;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_FILL;
            r_cnt      <= '0;
            r_inflight <= 1'b0;
            r_pack     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_inflight <= read_o;
            r_cnt      <= w_cnt_eff + CW'(r_inflight);
            if (r_inflight) begin
                r_pack[w_cnt_eff*Width +: Width] <= r_data_i;
            end
        end
    end

    assign busy_o = (r_state != ST_FILL) || (r_cnt != '0) || r_inflight;

    fifo_rd_out_stage #(
        .Width (Width),
        .Pack  (Pack)
    ) u_out_stage (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .i_load     (w_load),
        .i_data     (w_ld_data),
        .i_keep     (w_ld_keep),
        .i_last     (w_load_part),
        .o_can_load (w_can_load),
        .o_m_data   (m_data_o),
        .o_m_keep   (m_keep_o),
        .o_m_last   (m_last_o),
        .o_m_valid  (m_valid_o),
`ifdef FIFO_RD_PACKER_STATS_EN
        .o_beats    (beats_o),
        .o_stall    (stall_o),
`endif
        .i_m_ready  (m_ready_i)
    );

endmodule
